// File: rtl/ssc_pkg.sv
// Shared types and helpers for the SNG scheduler: job FSM states,
// default stream window length and a one-hot to index converter.
package ssc_pkg;

    localparam int SSC_STREAM_LEN = 256;
    localparam int SSC_OH_MAX     = 32;

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, STOP} state_t;

    function automatic int onehot_to_idx(input logic [SSC_OH_MAX-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < SSC_OH_MAX; i++)
            if (oh[i]) idx = i;
        return idx;
    endfunction

endpackage

// File: rtl/ssc_rr_arb.sv
// Combinational round-robin pick: search starts one past the last granted
// index and wraps, returning the first active request.
module ssc_rr_arb #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int c;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            c = (int'(ptr) + 1 + i) % N_REQ;
            if (!any && req[c]) begin
                any    = 1'b1;
                idx    = IDX_W'(c);
                gnt[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sng_sched.sv
// Shares one SNG between N_REQ requesters: round-robin grant, start/stop
// pulse sequencing around a fixed stream window, and ones-count return.
module sng_sched
    import ssc_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int X_W        = 4,
    parameter int STREAM_LEN = SSC_STREAM_LEN,
    parameter int CNT_W      = $clog2(STREAM_LEN + 1)
) (
    input  logic                 i_clk_ssc,
    input  logic                 i_rst_ssc,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [N_REQ*X_W-1:0] i_x_bn,
    input  logic                 i_flush,
    output logic [N_REQ-1:0]     o_gnt,
    output logic [N_REQ-1:0]     o_done,
    output logic [CNT_W-1:0]     o_cnt,
    output logic                 o_sn_bit,
    output logic                 o_sn_vld,
    output logic                 o_busy,
    output logic [X_W-1:0]       o_x_bn,
    output logic                 o_start_sng,
    output logic                 o_stop_sng,
    input  logic                 i_sn_bit
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WIN_W = $clog2(STREAM_LEN);

    state_t             state, state_nxt;
    logic [N_REQ-1:0]   win_oh, arb_gnt;
    logic [IDX_W-1:0]   ptr, arb_idx;
    logic               arb_any;
    logic [CNT_W-1:0]   ones_cnt, cnt_q;
    logic [WIN_W-1:0]   win_cnt;
    logic [X_W-1:0]     x_q;
    logic               aborted;
    logic               win_last, flush_ok;

    assign win_last = (win_cnt == WIN_W'(STREAM_LEN - 1));
    assign flush_ok = i_flush && (state == LOAD || state == START || state == RUN);

    ssc_rr_arb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req (i_req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_ff @(posedge i_clk_ssc or negedge i_rst_ssc) begin
        if (!i_rst_ssc) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_any) state_nxt = LOAD;
            LOAD:    state_nxt = flush_ok ? STOP : START;
            START:   state_nxt = flush_ok ? STOP : RUN;
            RUN:     if (flush_ok || win_last) state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_gnt       = '0;
        o_done      = '0;
        o_start_sng = 1'b0;
        o_stop_sng  = 1'b0;
        o_sn_vld    = 1'b0;
        o_sn_bit    = 1'b0;
        o_busy      = (state != IDLE);
        case (state)
            LOAD:  o_gnt = win_oh;
            START: begin
                o_gnt       = win_oh;
                o_start_sng = 1'b1;
            end
            RUN: begin
                o_gnt    = win_oh;
                o_sn_vld = 1'b1;
                o_sn_bit = i_sn_bit;
            end
            STOP: begin
                o_gnt      = win_oh;
                o_stop_sng = 1'b1;
                o_done     = aborted ? '0 : win_oh;
            end
            default: ;
        endcase
    end

    // Result register only loads on a window that ran to completion, so a
    // flushed job leaves the previous count visible.
    always_ff @(posedge i_clk_ssc or negedge i_rst_ssc) begin
        if (!i_rst_ssc) begin
            win_oh   <= '0;
            ptr      <= IDX_W'(N_REQ - 1);
            ones_cnt <= '0;
            cnt_q    <= '0;
            win_cnt  <= '0;
            x_q      <= '0;
            aborted  <= 1'b0;
        end else begin
            if (flush_ok) aborted <= 1'b1;
            case (state)
                IDLE: if (arb_any) begin
                    win_oh  <= arb_gnt;
                    x_q     <= i_x_bn[arb_idx*X_W +: X_W];
                    aborted <= 1'b0;
                end
                START: begin
                    ones_cnt <= '0;
                    win_cnt  <= '0;
                end
                RUN: begin
                    ones_cnt <= ones_cnt + CNT_W'(i_sn_bit);
                    win_cnt  <= win_cnt + WIN_W'(1);
                    if (win_last && !flush_ok)
                        cnt_q <= ones_cnt + CNT_W'(i_sn_bit);
                end
                STOP: ptr <= IDX_W'(onehot_to_idx(SSC_OH_MAX'(win_oh)));
                default: ;
            endcase
        end
    end

    assign o_cnt  = cnt_q;
    assign o_x_bn = x_q;

endmodule

// File: tb/tb_sng_sched.sv
// Bench for sng_sched: vector table of single jobs plus hand sequences for
// back-to-back, flush, reset and request-drop cases against an SNG model.
module tb_sng_sched;

    localparam int N  = 4;
    localparam int XW = 4;
    localparam int SL = 256;
    localparam int CW = $clog2(SL + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    i_req;
    logic [N*XW-1:0] i_x_bn;
    logic            i_flush;
    logic [N-1:0]    o_gnt, o_done;
    logic [CW-1:0]   o_cnt;
    logic            o_sn_bit, o_sn_vld, o_busy, o_start_sng, o_stop_sng;
    logic [XW-1:0]   o_x_bn;
    logic            i_sn_bit = 1'b0;

    always #5 clk = ~clk;

    sng_sched #(.N_REQ(N), .X_W(XW), .STREAM_LEN(SL)) dut (
        .i_clk_ssc   (clk),
        .i_rst_ssc   (rst_n),
        .i_req       (i_req),
        .i_x_bn      (i_x_bn),
        .i_flush     (i_flush),
        .o_gnt       (o_gnt),
        .o_done      (o_done),
        .o_cnt       (o_cnt),
        .o_sn_bit    (o_sn_bit),
        .o_sn_vld    (o_sn_vld),
        .o_busy      (o_busy),
        .o_x_bn      (o_x_bn),
        .o_start_sng (o_start_sng),
        .o_stop_sng  (o_stop_sng),
        .i_sn_bit    (i_sn_bit)
    );

    typedef struct {
        logic [N-1:0] req;
        int           mode;
        int           xval;
        int           exp_idx;
        int           exp_x;
        int           exp_cnt;
    } vec_t;

    vec_t vecs[6];
    int   checks = 0, errors = 0;
    int   cyc = 0;
    int   mode = 0, xval = 0;
    int   n_start = 0, n_stop = 0;
    int   win_j = 0, acc = 0;
    int   last;
    logic b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    task automatic wait_gnt(input string nm);
        int t = 0;
        while (o_gnt == '0 && t < 400) begin @(negedge clk); t++; end
        if (o_gnt == '0) timeout(nm);
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (o_done == '0 && t < 400) begin @(negedge clk); t++; end
        if (o_done == '0) timeout(nm);
    endtask

    task automatic wait_start(input string nm);
        int t = 0;
        while (!o_start_sng && t < 400) begin @(negedge clk); t++; end
        if (!o_start_sng) timeout(nm);
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int lst);
        for (int i = 1; i <= N; i++)
            if (req[(lst + i) % N]) return (lst + i) % N;
        return -1;
    endfunction

    function automatic logic pat(input int j);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (j % 16) < xval;
            default: return 1'($urandom % 2);
        endcase
    endfunction

    // SNG model and scoreboard: supplies the stream during the window and
    // tallies the ones it supplied as the expected back-converted count.
    always @(negedge clk) begin
        if (!rst_n) begin
            win_j = 0;
            acc   = 0;
        end else begin
            if (o_start_sng && o_stop_sng) chk("start_stop_overlap", 1, 0);
            if (o_start_sng) begin n_start++; win_j = 0; acc = 0; end
            if (o_sn_vld) begin
                b = pat(win_j);
                i_sn_bit = b;
                acc += int'(b);
                win_j++;
                #1 chk("sn_bit_pass", o_sn_bit, b);
            end else begin
                i_sn_bit = 1'($urandom % 2);
            end
            if (o_stop_sng) n_stop++;
            if (o_done != '0) begin
                chk("window_len", win_j, SL);
                chk("done_cnt_model", o_cnt, acc);
                chk("done_is_gnt", o_done, o_gnt);
            end
        end
    end

    initial begin
        int t0, s0, p0, eidx, dprev, cnt_before;
        logic [N-1:0] cur_req;
        rst_n   = 1'b0;
        i_req   = '0;
        i_flush = 1'b0;
        i_x_bn  = {4'd9, 4'd3, 4'd12, 4'd6};
        vecs[0] = '{4'b0001, 2, 6,  0, 6,  96};
        vecs[1] = '{4'b0001, 1, 0,  0, 6,  256};
        vecs[2] = '{4'b0001, 0, 0,  0, 6,  0};
        vecs[3] = '{4'b1000, 2, 15, 3, 9,  240};
        vecs[4] = '{4'b1001, 2, 1,  0, 6,  16};
        vecs[5] = '{4'b0110, 2, 9,  1, 12, 144};

        repeat (3) @(negedge clk);
        #1 chk("reset_outs", {o_gnt, o_done, o_cnt, o_sn_bit, o_sn_vld, o_busy,
                               o_x_bn, o_start_sng, o_stop_sng}, 0);
        @(negedge clk) rst_n = 1'b1;
        last = N - 1;
        repeat (2) @(negedge clk);

        for (int e = 0; e < 6; e++) begin
            s0 = n_start; p0 = n_stop;
            mode = vecs[e].mode; xval = vecs[e].xval;
            @(negedge clk);
            i_req = vecs[e].req;
            t0 = cyc;
            wait_gnt("vec_gnt_wait");
            chk("vec_gnt", o_gnt, 1 << vecs[e].exp_idx);
            chk("vec_x", o_x_bn, vecs[e].exp_x);
            i_req = '0;
            wait_done("vec_done_wait");
            chk("vec_done", o_done, 1 << vecs[e].exp_idx);
            chk("vec_cnt", o_cnt, vecs[e].exp_cnt);
            chk("vec_latency", cyc - t0, 259);
            last = vecs[e].exp_idx;
            repeat (2) @(negedge clk);
            chk("vec_starts", n_start - s0, 1);
            chk("vec_stops", n_stop - p0, 1);
            chk("vec_cnt_hold", o_cnt, vecs[e].exp_cnt);
        end

        // Reset in the middle of a window, then a back-to-back run.
        mode = 3;
        @(negedge clk);
        i_req = 4'b0100;
        eidx = rr_pick(i_req, last);
        wait_gnt("rst_gnt_wait");
        chk("rst_job_gnt", o_gnt, 1 << eidx);
        i_req = '0;
        wait_start("rst_start_wait");
        repeat (51) @(negedge clk);
        p0 = n_stop;
        #3 rst_n = 1'b0;
        #1 chk("midjob_reset_outs", {o_gnt, o_done, o_cnt, o_sn_bit, o_sn_vld, o_busy,
                                      o_x_bn, o_start_sng, o_stop_sng}, 0);
        i_req = 4'b0101;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last = N - 1;
        chk("rst_no_stop", n_stop - p0, 0);
        cur_req = 4'b0101;
        dprev = 0;
        for (int k = 0; k < 5; k++) begin
            eidx = rr_pick(cur_req, last);
            wait_gnt("b2b_gnt_wait");
            chk("b2b_gnt", o_gnt, 1 << eidx);
            if (k == 0) begin i_req = 4'b1111; cur_req = 4'b1111; end
            if (k == 4) i_req = '0;
            wait_done("b2b_done_wait");
            chk("b2b_done", o_done, 1 << eidx);
            if (k > 0) chk("b2b_period", cyc - dprev, 260);
            dprev = cyc;
            last = eidx;
            @(negedge clk);
        end

        // Requester drops its request mid-window.
        @(negedge clk);
        i_req = 4'b1000;
        eidx = rr_pick(i_req, last);
        wait_gnt("drop_gnt_wait");
        chk("drop_gnt", o_gnt, 1 << eidx);
        wait_start("drop_start_wait");
        repeat (10) @(negedge clk);
        i_req = '0;
        wait_done("drop_done_wait");
        chk("drop_done", o_done, 4'b1000);
        chk("drop_cnt", o_cnt, acc);
        last = eidx;
        repeat (2) @(negedge clk);

        // Flush at window cycle 100 with a second requester waiting.
        i_req = 4'b0011;
        eidx = rr_pick(i_req, last);
        wait_gnt("flush_gnt_wait");
        chk("flush_gnt", o_gnt, 1 << eidx);
        wait_start("flush_start_wait");
        repeat (101) @(negedge clk);
        cnt_before = int'(o_cnt);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        chk("flush_stop", o_stop_sng, 1);
        chk("flush_no_done", o_done, 0);
        chk("flush_cnt_held", o_cnt, cnt_before);
        last = eidx;
        @(negedge clk);
        eidx = rr_pick(i_req, last);
        wait_gnt("after_flush_gnt_wait");
        chk("after_flush_gnt", o_gnt, 1 << eidx);
        i_req = '0;
        wait_done("after_flush_done_wait");
        chk("after_flush_done", o_done, 1 << eidx);
        last = eidx;
        repeat (2) @(negedge clk);

        // Flush during the start cycle still issues exactly one start.
        i_req = 4'b0100;
        eidx = rr_pick(i_req, last);
        wait_gnt("fstart_gnt_wait");
        chk("fstart_gnt", o_gnt, 1 << eidx);
        i_req = '0;
        s0 = n_start;
        wait_start("fstart_start_wait");
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        chk("fstart_stop", o_stop_sng, 1);
        chk("fstart_no_done", o_done, 0);
        @(negedge clk);
        chk("fstart_idle", o_busy, 0);
        chk("fstart_one_start", n_start - s0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
